scan_decoder: RTL and testbench
===============================

# scan_decoder

Registered, parametrised N-to-2^N decoder with active-low one-hot outputs, two-signal enable and an autonomous scan mode. In direct mode it decodes the selected index; in scan mode an internal counter walks every output in turn at a programmable dwell rate. It is the select/strobe generator for multiplexed LED and seven-segment digit driving on the lab boards.

## Interface
- SEL_W, 3: index width; output width is 2^SEL_W.
- PRESCALE, 4: dwell, in enabled clock cycles, per index in scan mode. Legal range is 1 to 65535.
- iClk  input  1  system clock; all logic is on the rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iData  input  SEL_W  index to decode in direct mode; start index when scan mode is entered.
- iEna  input  2  enable {G1,G2}; the block is enabled only when the value is 2'b10.
- iMode  input  1  0 = direct decode; 1 = auto scan.
- oData  output  2^SEL_W  decoded outputs, active low; bit k is low when index k is selected.
- oIndex  output  SEL_W  index currently driven on oData.
- oValid  output  1  high when exactly one oData bit is low.
- oWrap  output  1  one-cycle pulse when the scan index wraps from 2^SEL_W-1 to 0.

## Operation
- State machine with three states: IDLE, DIRECT and SCAN. All outputs are registered.
- Reset values:
  - oData is all ones; oIndex, oValid and oWrap are 0.
  - The state is IDLE; the scan index and dwell counter are 0.
- State transitions, evaluated every cycle:
  - iEna != 2'b10 goes to IDLE from any state.
  - When enabled, iMode=0 goes to DIRECT and iMode=1 goes to SCAN.
- IDLE:
  - oData is all ones; oValid and oWrap are 0.
  - oIndex holds its last value, and the scan index and dwell counter hold their values. Disabling pauses the scan; it does not restart it.
- DIRECT:
  - oData becomes ~(1 << iData), oIndex becomes iData and oValid becomes 1.
  - The scan index and dwell counter are untouched.
- SCAN entry, from IDLE or DIRECT:
  - The scan index loads iData and the dwell counter clears to 0.
  - oData and oIndex show iData in the same update.
- SCAN steady state:
  - The dwell counter increments each cycle.
  - When the counter reaches PRESCALE-1, it clears and the scan index advances by 1, modulo 2^SEL_W.
  - Advancing from 2^SEL_W-1 to 0 asserts oWrap for exactly that one cycle.
- Resume from IDLE into SCAN is still an entry: the scan index reloads from iData.
- Simultaneous events:
  - A disable wins over a dwell expiry. The index does not advance and oWrap stays 0.
  - A mode change wins over a dwell expiry.
- Reset asserted mid-scan forces all reset values immediately, asynchronously. Release takes effect on the next iClk edge.
- Dwell counter width is clog2(PRESCALE), minimum 1 bit. For PRESCALE=1, the index advances every cycle.

## Timing
- Direct-mode latency is 1 cycle: iData and iEna sampled at edge n appear on oData after edge n.
- Enable to first valid output is 1 cycle. Disable to all-ones is 1 cycle.
- Scan mode with no blanking:
  - Each index is shown for exactly PRESCALE cycles.
  - A full sweep takes PRESCALE × 2^SEL_W cycles.
- oWrap rises in the same cycle that oIndex becomes 0 after a wrap.
- There is no oWrap on scan entry, even if the entry index is 0.

## Configuration
- SCAN_DECODER_BLANK_EN defined:
  - In SCAN, the first cycle of every dwell period after an index advance drives oData all ones with oValid=0. This suppresses ghosting on multiplexed displays.
  - oIndex already shows the new index during that blank cycle.
  - oWrap still pulses at the wrap advance.
  - The dwell period stays PRESCALE cycles, including the blank cycle.
  - With PRESCALE=1 there is no blanking.
  - Scan entry is not blanked.
- SCAN_DECODER_BLANK_EN undefined: index changes are immediate, with no blank cycles.

## Test plan
- Reset and defaults:
  - Hold iRst_n=0 for 3 cycles -> oData=8'hFF, oIndex=0, oValid=0, oWrap=0.
  - Assert reset mid-scan at index 5 -> the same values immediately, without waiting for a clock.
- Direct sweep:
  - Set iEna=2'b10, iMode=0, and iData=0..7 on successive cycles -> oData=8'hFE, FD, FB, F7, EF, DF, BF, 7F, each one cycle later.
  - Set iEna to 2'b00, 2'b11 or 2'b01 -> 8'hFF.
- Scan, PRESCALE=4:
  - Enter with iData=6 -> index 6 for 4 cycles, then 7 for 4 cycles, then 0 with oWrap=1 for one cycle, then 1.
  - A full sweep is 32 cycles.
- Pause:
  - In scan, drop iEna to 2'b00 for 5 cycles at dwell count 2 -> oData=8'hFF and the counter frozen.
  - Re-enable -> the index reloads from iData and the counter clears.
- Boundaries:
  - PRESCALE=1, SEL_W=2 -> the index advances every cycle (0,1,2,3,0) and oWrap=1 on every 4th cycle.
  - A disable coinciding with dwell expiry -> no advance and no oWrap.
- SCAN_DECODER_BLANK_EN with PRESCALE=4:
  - Scan from index 0 -> oData sequence FE, FE, FE, FE, FF, FD, FD, FD, FF, FB.
  - oValid=0 exactly on the FF cycles.

Source files
------------

// File: rtl/scan_decoder.sv
// Registered N-to-2^N active-low decoder with direct and auto-scan modes.
// Optional blank cycle after each scan advance: define SCAN_DECODER_BLANK_EN.
module scan_decoder #(
  parameter int SEL_W    = 3,
  parameter int PRESCALE = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [SEL_W-1:0]      iData,
  input  logic [1:0]            iEna,
  input  logic                  iMode,
  output logic [2**SEL_W-1:0]   oData,
  output logic [SEL_W-1:0]      oIndex,
  output logic                  oValid,
  output logic                  oWrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

`ifdef SCAN_DECODER_BLANK_EN
  localparam bit BLANK_EN = (PRESCALE > 1);
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   index_q, index_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic               enabled;
  logic [SEL_W-1:0]   next_idx;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
    return ~(OUT_W'(1) << idx);
  endfunction

  assign enabled  = (iEna == 2'b10);
  assign next_idx = scan_idx_q + SEL_W'(1);

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    index_d    = index_q;
    valid_d    = valid_q;
    wrap_d     = 1'b0;
    if (!enabled) begin
      state_d = IDLE;
      data_d  = '1;
      valid_d = 1'b0;
    end else if (!iMode) begin
      state_d = DIRECT;
      data_d  = decode(iData);
      index_d = iData;
      valid_d = 1'b1;
    end else if (state_q != SCAN) begin
      state_d    = SCAN;
      scan_idx_d = iData;
      cnt_d      = '0;
      data_d     = decode(iData);
      index_d    = iData;
      valid_d    = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      // Disable and mode change are handled above, so they already win over expiry.
      cnt_d      = '0;
      scan_idx_d = next_idx;
      index_d    = next_idx;
      wrap_d     = (scan_idx_q == '1);
      data_d     = BLANK_EN ? '1 : decode(next_idx);
      valid_d    = !BLANK_EN;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      data_d  = decode(scan_idx_q);
      index_d = scan_idx_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      scan_idx_q <= '0;
      cnt_q      <= '0;
      data_q     <= '1;
      index_q    <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      index_q    <= index_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign oData  = data_q;
  assign oIndex = index_q;
  assign oValid = valid_q;
  assign oWrap  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: two instances (SEL_W=3/PRESCALE=4 and
// SEL_W=2/PRESCALE=1) checked against a position-based reference model.
module tb_scan_decoder;

`ifdef SCAN_DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    bit       scanning;
    int       pos;      // absolute position in the sweep: index*PRESCALE + elapsed
    logic [7:0] data;   // expected oData, upper unused bits held at 1
    int       idx;
    bit       valid;
    bit       wrap;
  } model_t;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic [2:0] iData = '0;
  logic [1:0] iEna = '0;
  logic       iMode = 1'b0;

  logic [7:0] oData_a;
  logic [2:0] oIndex_a;
  logic       oValid_a, oWrap_a;
  logic [3:0] oData_b;
  logic [1:0] oIndex_b;
  logic       oValid_b, oWrap_b;

  int errors = 0;
  int checks = 0;
  model_t ma, mb;
  model_t qa[$];
  model_t qb[$];

  always #5 iClk = ~iClk;

  scan_decoder #(.SEL_W(3), .PRESCALE(4)) dut_a (
    .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iEna(iEna), .iMode(iMode),
    .oData(oData_a), .oIndex(oIndex_a), .oValid(oValid_a), .oWrap(oWrap_a)
  );

  scan_decoder #(.SEL_W(2), .PRESCALE(1)) dut_b (
    .iClk(iClk), .iRst_n(iRst_n), .iData(iData[1:0]), .iEna(iEna), .iMode(iMode),
    .oData(oData_b), .oIndex(oIndex_b), .oValid(oValid_b), .oWrap(oWrap_b)
  );

  function automatic model_t reset_model();
    model_t r;
    r.scanning = 0; r.pos = 0; r.data = 8'hFF; r.idx = 0; r.valid = 0; r.wrap = 0;
    return r;
  endfunction

  function automatic model_t advance(model_t m, int p, int n, logic [1:0] ena,
                                     logic mode, int d_in);
    model_t r = m;
    int d = d_in % n;
    bit blank;
    r.wrap = 0;
    if (ena != 2'b10) begin
      r.scanning = 0; r.data = 8'hFF; r.valid = 0;
    end else if (!mode) begin
      r.scanning = 0; r.idx = d; r.data = ~(8'd1 << d); r.valid = 1;
    end else if (!m.scanning) begin
      r.scanning = 1; r.pos = d * p; r.idx = d; r.data = ~(8'd1 << d); r.valid = 1;
    end else begin
      r.pos   = (m.pos + 1) % (p * n);
      r.idx   = r.pos / p;
      r.wrap  = (r.pos == 0);
      blank   = BLANK && (p > 1) && (r.pos % p == 0);
      r.data  = blank ? 8'hFF : ~(8'd1 << r.idx);
      r.valid = !blank;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge iClk) begin
    model_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_data", int'(oData_a), int'(e.data));
      chk("a_index", int'(oIndex_a), e.idx);
      chk("a_valid", int'(oValid_a), int'(e.valid));
      chk("a_wrap", int'(oWrap_a), int'(e.wrap));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_data", int'({4'hF, oData_b}), int'(e.data));
      chk("b_index", int'(oIndex_b), e.idx);
      chk("b_valid", int'(oValid_b), int'(e.valid));
      chk("b_wrap", int'(oWrap_b), int'(e.wrap));
    end
  end

  task automatic step(input logic r, input logic [1:0] e, input logic m, input logic [2:0] d);
    @(negedge iClk);
    #1;
    iRst_n = r; iEna = e; iMode = m; iData = d;
    @(posedge iClk);
    if (!iRst_n) begin
      ma = reset_model();
      mb = reset_model();
    end else begin
      ma = advance(ma, 4, 8, iEna, iMode, int'(iData));
      mb = advance(mb, 1, 4, iEna, iMode, int'(iData));
    end
    qa.push_back(ma);
    qb.push_back(mb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic cur_mode;
    logic [1:0] e;
    ma = reset_model();
    mb = reset_model();

    repeat (3) step(1'b0, 2'b10, 1'b0, 3'd0);

    for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 1'b0, 3'(i));
    step(1'b1, 2'b00, 1'b0, 3'd3);
    step(1'b1, 2'b11, 1'b0, 3'd3);
    step(1'b1, 2'b01, 1'b0, 3'd3);

    step(1'b1, 2'b10, 1'b1, 3'd6);
    repeat (40) step(1'b1, 2'b10, 1'b1, 3'd1);

    // Pause at dwell count 2, then resume with a fresh entry index.
    step(1'b1, 2'b10, 1'b0, 3'd0);
    step(1'b1, 2'b10, 1'b1, 3'd2);
    repeat (2) step(1'b1, 2'b10, 1'b1, 3'd0);
    repeat (5) step(1'b1, 2'b00, 1'b1, 3'd0);
    step(1'b1, 2'b10, 1'b1, 3'd3);
    repeat (10) step(1'b1, 2'b10, 1'b1, 3'd0);

    // Disable coinciding with a wrapping expiry.
    step(1'b1, 2'b00, 1'b1, 3'd0);
    step(1'b1, 2'b10, 1'b1, 3'd7);
    repeat (3) step(1'b1, 2'b10, 1'b1, 3'd0);
    step(1'b1, 2'b01, 1'b1, 3'd0);
    step(1'b1, 2'b01, 1'b1, 3'd0);

    // Mode change coinciding with an expiry.
    step(1'b1, 2'b10, 1'b1, 3'd3);
    repeat (3) step(1'b1, 2'b10, 1'b1, 3'd0);
    step(1'b1, 2'b10, 1'b0, 3'd5);

    cur_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
      e = ($urandom_range(0, 9) < 8) ? 2'b10 : 2'($urandom);
      step(1'b1, e, cur_mode, 3'($urandom));
    end

    // Asynchronous reset mid-scan at index 5.
    step(1'b1, 2'b00, 1'b1, 3'd0);
    step(1'b1, 2'b10, 1'b1, 3'd5);
    step(1'b1, 2'b10, 1'b1, 3'd0);
    @(negedge iClk);
    #2;
    chk("pre_rst_index_a", int'(oIndex_a), 5);
    iRst_n = 1'b0;
    #1;
    chk("async_rst_data_a", int'(oData_a), 'hFF);
    chk("async_rst_index_a", int'(oIndex_a), 0);
    chk("async_rst_valid_a", int'(oValid_a), 0);
    chk("async_rst_data_b", int'(oData_b), 'hF);
    chk("async_rst_valid_b", int'(oValid_b), 0);
    ma = reset_model();
    mb = reset_model();
    step(1'b0, 2'b10, 1'b1, 3'd0);
    step(1'b1, 2'b10, 1'b1, 3'd0);
    repeat (12) step(1'b1, 2'b10, 1'b1, 3'd0);

    @(negedge iClk);
    #1;
    chk("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
